digit_blitter: RTL
==================

// Module: digit_blitter
// PURPOSE
//  Writer side of the number-bitmap path: copies one decimal digit glyph (0-9) from
//  the glyph ROM into the 1-port VGA frame-buffer RAM at a requested pixel origin.
//  The VGA scan side (H/V counters) reads that RAM; this block only ever writes it.
//  One digit per START; the score/timer controller issues digits one after another.
// PARAMETERS
//  GLYPH_W   8    glyph width in pixels (columns per row)
//  GLYPH_H   12   glyph height in pixels (rows)
//  FB_W      160  frame-buffer width in pixels
//  FB_H      120  frame-buffer height in pixels
//  FB_AW     15   frame-buffer address width (FB_W*FB_H <= 2**FB_AW)
//  ROM_AW    10   glyph ROM address width (10*GLYPH_W*GLYPH_H <= 2**ROM_AW)
//  COL_W     8    colour word width
// PORTS
//  CLK       in   1       system clock, all logic on rising edge
//  RESET     in   1       asynchronous, active-high reset
//  START     in   1       request; sampled only in IDLE
//  DIGIT     in   4       digit value, latched on accepted START
//  X0        in   8       glyph origin column (left), latched on START
//  Y0        in   7       glyph origin row (top), latched on START
//  FG_COL    in   COL_W   colour for glyph bit 1, latched on START
//  BG_COL    in   COL_W   colour for glyph bit 0, latched on START
//  TRANSP    in   1       1 = glyph bit 0 pixels not written, latched on START
//  ROM_ADDR  out  ROM_AW  glyph ROM address; ROM has 1-cycle synchronous read
//  ROM_DATA  in   1       glyph bit, valid the cycle after ROM_ADDR
//  FB_ADDR   out  FB_AW   frame-buffer write address = y*FB_W + x
//  FB_DATA   out  COL_W   frame-buffer write data
//  FB_WE     out  1       frame-buffer write strobe, one pixel per cycle
//  BUSY      out  1       high while copy in progress
//  DONE      out  1       1-cycle pulse when copy (or reject) finishes
//  ERR       out  1       1-cycle pulse with DONE when DIGIT > 9
// BEHAVIOUR
//  Reset: state IDLE; ROM_ADDR, FB_ADDR, FB_DATA = 0; FB_WE, BUSY, DONE, ERR = 0.
//  Reset mid-copy aborts immediately (async); FB_WE drops without waiting for a clock.
//  States: IDLE -> COPY -> DRAIN -> FIN -> IDLE.
//  IDLE: START=1 at edge T latches inputs. DIGIT>9 -> FIN directly, no ROM/FB access,
//   DONE=ERR=1 in cycle T+1. Else -> COPY, BUSY=1 from T+1.
//  COPY: col counter 0..GLYPH_W-1 (inner), row counter 0..GLYPH_H-1 (outer); one
//   pixel k per cycle, ROM_ADDR=(DIGIT*GLYPH_H+row)*GLYPH_W+col in cycle T+1+k.
//   Column wraps to 0 and row increments on col=GLYPH_W-1; after last pixel -> DRAIN.
//  Pipeline: row/col delayed 1 cycle to align with ROM_DATA; FB outputs registered.
//   Pixel k: FB_WE/FB_ADDR/FB_DATA valid in cycle T+3+k (latency 2 from ROM_ADDR).
//  FB_DATA = ROM_DATA ? FG_COL : BG_COL. FB_WE=0 for a pixel if TRANSP=1 and bit=0.
//  Clipping: pixel x=X0+col >= FB_W or y=Y0+row >= FB_H -> FB_WE=0 (no wrap-around);
//   x,y computed 1 bit wider than X0/Y0 so overflow is detected, never truncated.
//  FB_ADDR computed as y*FB_W+x in FB_AW bits; only valid when FB_WE=1.
//  DRAIN: waits for last write; FIN: DONE=1 one cycle, BUSY=0, then IDLE.
//  Full copy (N=GLYPH_W*GLYPH_H=96): BUSY T+1..T+N+2, last FB_WE T+N+2, DONE T+N+3.
//  START while BUSY or in FIN is ignored (not queued). New START accepted the cycle
//   after DONE. Latched inputs unaffected by input changes during copy.
//  FB_WE never high outside COPY/DRAIN; ROM_ADDR holds last value when idle.
// TESTING
//  1. RESET pulse mid-copy (pixel 40) -> FB_WE=0, BUSY=0 immediately; next START copies cleanly.
//  2. DIGIT=3,X0=10,Y0=20,TRANSP=0 -> 96 writes, first FB_ADDR=3210, last 4977;
//     FB_DATA matches ROM bitmap of '3'; DONE at T+99.
//  3. Same with TRANSP=1 -> writes only where glyph bit=1; count equals popcount of '3'.
//  4. X0=155,Y0=115 -> only cols 0..4, rows 0..4 written (25 max); no address >= 19200.
//  5. DIGIT=12 -> DONE=ERR=1 at T+1, zero FB_WE, zero ROM accesses.
//  6. START held high continuously, DIGIT=0 then 9 -> back-to-back copies, second
//     starts the cycle after first DONE; START pulses during BUSY ignored.

Source files
------------

// File: rtl/digit_blitter.sv
// Digit blitter: copies one 8x12 decimal glyph from the glyph ROM into the
// frame-buffer RAM at a requested origin, one pixel per cycle, with clipping,
// optional transparency and a 2-stage pipeline matching the synchronous ROM.
module digit_blitter #(
  parameter int unsigned GLYPH_W = 8,
  parameter int unsigned GLYPH_H = 12,
  parameter int unsigned FB_W    = 160,
  parameter int unsigned FB_H    = 120,
  parameter int unsigned FB_AW   = 15,
  parameter int unsigned ROM_AW  = 10,
  parameter int unsigned COL_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [3:0]        DIGIT,
  input  logic [7:0]        X0,
  input  logic [6:0]        Y0,
  input  logic [COL_W-1:0]  FG_COL,
  input  logic [COL_W-1:0]  BG_COL,
  input  logic              TRANSP,
  output logic [ROM_AW-1:0] ROM_ADDR,
  input  logic              ROM_DATA,
  output logic [FB_AW-1:0]  FB_ADDR,
  output logic [COL_W-1:0]  FB_DATA,
  output logic              FB_WE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int unsigned CW = $clog2(GLYPH_W);
  localparam int unsigned RW = $clog2(GLYPH_H);

  typedef enum logic [1:0] {StIdle, StCopy, StDrain, StFin} state_e;

  state_e state_q, state_d;

  // Latched request
  logic [3:0]       digit_q, digit_d;
  logic [7:0]       x0_q, x0_d;
  logic [6:0]       y0_q, y0_d;
  logic [COL_W-1:0] fg_q, fg_d, bg_q, bg_d;
  logic             transp_q, transp_d;
  logic             err_q, err_d;

  // Scan counters (stage 0, drive ROM_ADDR)
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Stage 1: pixel position aligned with ROM_DATA
  logic          v1_q, v1_d;
  logic [CW-1:0] col1_q, col1_d;
  logic [RW-1:0] row1_q, row1_d;

  // Stage 2: registered frame-buffer write port
  logic             fb_we_q, fb_we_d;
  logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
  logic [COL_W-1:0] fb_data_q, fb_data_d;

  logic       last_px;
  logic       accept;
  logic [8:0] px_x;
  logic [7:0] px_y;
  logic       in_range;

  assign last_px = (col_q == CW'(GLYPH_W - 1)) && (row_q == RW'(GLYPH_H - 1));
  // Digit values above 9 are rejected without touching ROM or frame buffer
  assign accept  = (state_q == StIdle) && START && (DIGIT <= 4'd9);

  // One bit wider than the origin so an overflow past the edge is clipped, not wrapped
  assign px_x     = {1'b0, x0_q} + 9'(col1_q);
  assign px_y     = {1'b0, y0_q} + 8'(row1_q);
  assign in_range = (32'(px_x) < FB_W) && (32'(px_y) < FB_H);

  // State register and all datapath flops
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      digit_q   <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      fg_q      <= '0;
      bg_q      <= '0;
      transp_q  <= 1'b0;
      err_q     <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      v1_q      <= 1'b0;
      col1_q    <= '0;
      row1_q    <= '0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      fg_q      <= fg_d;
      bg_q      <= bg_d;
      transp_q  <= transp_d;
      err_q     <= err_d;
      col_q     <= col_d;
      row_q     <= row_d;
      v1_q      <= v1_d;
      col1_q    <= col1_d;
      row1_q    <= row1_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (START) state_d = (DIGIT > 4'd9) ? StFin : StCopy;
      StCopy:  if (last_px) state_d = StDrain;
      StDrain: if (!v1_q) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch, scan counters and write pipeline
  always_comb begin
    digit_d  = digit_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    transp_d = transp_q;
    err_d    = err_q;
    col_d    = col_q;
    row_d    = row_q;

    if (state_q == StIdle && START) err_d = (DIGIT > 4'd9);

    if (accept) begin
      digit_d  = DIGIT;
      x0_d     = X0;
      y0_d     = Y0;
      fg_d     = FG_COL;
      bg_d     = BG_COL;
      transp_d = TRANSP;
      col_d    = '0;
      row_d    = '0;
    end else if (state_q == StCopy && !last_px) begin
      // Counters hold on the last pixel so ROM_ADDR keeps its final value when idle
      if (col_q == CW'(GLYPH_W - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    v1_d   = (state_q == StCopy);
    col1_d = col_q;
    row1_d = row_q;

    fb_we_d   = v1_q && in_range && (ROM_DATA || !transp_q);
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    if (v1_q) begin
      fb_addr_d = FB_AW'(32'(px_y) * FB_W + 32'(px_x));
      fb_data_d = ROM_DATA ? fg_q : bg_q;
    end
  end

  // Outputs
  always_comb begin
    ROM_ADDR = ROM_AW'((32'(digit_q) * GLYPH_H + 32'(row_q)) * GLYPH_W + 32'(col_q));
    FB_WE    = fb_we_q;
    FB_ADDR  = fb_addr_q;
    FB_DATA  = fb_data_q;
    BUSY     = (state_q == StCopy) || (state_q == StDrain);
    DONE     = (state_q == StFin);
    ERR      = (state_q == StFin) && err_q;
  end

endmodule
